// File: rtl/bint_ident_pkg.sv
// Shared constants and types for the bus interrupt ident responder.
package bint_ident_pkg;

  localparam int IDENT_W_DEF = 9;

  localparam logic [1:0] LEV10 = 2'd0;
  localparam logic [1:0] LEV11 = 2'd1;
  localparam logic [1:0] LEV12 = 2'd2;
  localparam logic [1:0] LEV13 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    NOREP = 2'd2
  } state_t;

endpackage

// File: rtl/bint_ident_responder_if.sv
// Device request, CPU ident strobe and bus interrupt lines of the responder.
interface bint_ident_responder_if
  import bint_ident_pkg::*;
#(
  parameter int IDENT_W = IDENT_W_DEF
);

  logic               REQ_VALID;
  logic [1:0]         REQ_LEV;
  logic [IDENT_W-1:0] REQ_CODE;
  logic               REQ_READY;
  logic [3:0]         LEVMASK;
  logic               IDENTN;
  logic [1:0]         IDLEV;
  logic               BINT10N;
  logic               BINT11N;
  logic               BINT12N;
  logic               BINT13N;
  logic               IDACKN;
  logic [IDENT_W-1:0] IDCODE;
  logic [3:0]         PEND_3_0;

  modport master (
    output REQ_VALID, REQ_LEV, REQ_CODE, LEVMASK, IDENTN, IDLEV,
    input  REQ_READY, BINT10N, BINT11N, BINT12N, BINT13N, IDACKN, IDCODE, PEND_3_0
  );

  modport slave (
    input  REQ_VALID, REQ_LEV, REQ_CODE, LEVMASK, IDENTN, IDLEV,
    output REQ_READY, BINT10N, BINT11N, BINT12N, BINT13N, IDACKN, IDCODE, PEND_3_0
  );

endinterface

// File: rtl/bint_ident_fifo.sv
// Per-level ident code queue; head is the oldest entry, valid while not empty.
module bint_ident_fifo #(
  parameter int IDENT_W = 9,
  parameter int DEPTH   = 2,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               push,
  input  logic               pop,
  input  logic [IDENT_W-1:0] din,
  output logic [IDENT_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [IDENT_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/bint_ident_responder.sv
// Queues ident codes per level 10-13, drives BINTnN and answers CPU ident cycles.
module bint_ident_responder
  import bint_ident_pkg::*;
#(
  parameter int IDENT_W = IDENT_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                   MCLK,
  input  logic                   RESET,
  bint_ident_responder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [IDENT_W-1:0] head [4];
  logic [CW-1:0]      count [4];
  logic [3:0]         full, empty, push, pop;

  state_t             state_reg, state_next;
  logic [1:0]         lev_reg, code_lev;
  logic               idprev_reg, fall, resp_ok;
  logic               idackn_reg, idackn_next;
  logic [IDENT_W-1:0] idcode_reg, idcode_next;
  logic [3:0]         bint_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lev
      assign push[gi] = bus.REQ_VALID && bus.REQ_READY && (bus.REQ_LEV == 2'(gi));
      assign pop[gi]  = (state_reg == RESP) && bus.IDENTN && (lev_reg == 2'(gi));

      bint_ident_fifo #(
        .IDENT_W (IDENT_W),
        .DEPTH   (DEPTH)
      ) u_fifo (
        .clk   (MCLK),
        .srst  (RESET),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (bus.REQ_CODE),
        .head  (head[gi]),
        .count (count[gi]),
        .full  (full[gi]),
        .empty (empty[gi])
      );
    end
  endgenerate

  assign bus.REQ_READY = !full[bus.REQ_LEV];
  assign bus.PEND_3_0  = ~empty;
  assign fall          = idprev_reg && !bus.IDENTN;
  assign resp_ok       = (count[bus.IDLEV] != '0) && bus.LEVMASK[bus.IDLEV];

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      lev_reg    <= LEV10;
      idprev_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idprev_reg <= bus.IDENTN;
      if (state_reg == IDLE && fall) lev_reg <= bus.IDLEV;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fall) state_next = resp_ok ? RESP : NOREP;
      RESP:    if (bus.IDENTN) state_next = IDLE;
      NOREP:   if (bus.IDENTN) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The head of lev_reg cannot move during RESP, so re-sampling it keeps IDCODE stable.
  always_comb begin
    code_lev    = (state_reg == IDLE) ? bus.IDLEV : lev_reg;
    idackn_next = (state_next != RESP);
    idcode_next = (state_next == RESP) ? head[code_lev] : '0;
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      idackn_reg <= 1'b1;
      idcode_reg <= '0;
      bint_reg   <= 4'hF;
    end else begin
      idackn_reg <= idackn_next;
      idcode_reg <= idcode_next;
      bint_reg   <= ~(~empty & bus.LEVMASK);
    end
  end

  assign bus.IDACKN  = idackn_reg;
  assign bus.IDCODE  = idcode_reg;
  assign bus.BINT10N = bint_reg[LEV10];
  assign bus.BINT11N = bint_reg[LEV11];
  assign bus.BINT12N = bint_reg[LEV12];
  assign bus.BINT13N = bint_reg[LEV13];

endmodule
